// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
    localparam logic [3:0]  REGION_BIOS  = 4'h4;
    localparam logic [3:0]  REGION_IMEM  = 4'h1;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side bus to the synchronous-read BIOS and IMEM instruction ports.
interface if_stage_if #(
    parameter int unsigned BIOS_AW = 12,
    parameter int unsigned IMEM_AW = 14
);

    logic [BIOS_AW-1:0] bios_addr;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        bios_dout;
    logic [31:0]        imem_dout;

    modport master (
        output bios_addr,
        output imem_addr,
        input  bios_dout,
        input  imem_dout
    );

    modport slave (
        input  bios_addr,
        input  imem_addr,
        output bios_dout,
        output imem_dout
    );

endinterface

// File: rtl/if_stage_pc_sel.sv
// Combinational next-PC priority mux: reset, EX redirect, stall, ID redirect, boot hold, sequential.
module if_stage_pc_sel
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        rst,
    input  logic        stall_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] ex_target_i,
    input  logic        id_redirect_i,
    input  logic [31:0] id_target_i,
    input  logic        boot_i,
    input  logic [31:0] pc_q_i,
    output logic [31:0] fetch_addr_o
);

    // Redirect targets are forced word-aligned; the low bits are dropped here.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^{ex_target_i[1:0], id_target_i[1:0]};

    always_comb begin
        fetch_addr_o = pc_q_i + 32'd4;
        if (!rst) begin
            fetch_addr_o = RESET_PC;
        end else if (ex_redirect_i) begin
            fetch_addr_o = {ex_target_i[31:2], 2'b00};
        end else if (stall_i) begin
            fetch_addr_o = pc_q_i;
        end else if (id_redirect_i) begin
            fetch_addr_o = {id_target_i[31:2], 2'b00};
        end else if (boot_i) begin
            fetch_addr_o = pc_q_i;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, memory address drive, region select and retired-fetch counter.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned BIOS_AW  = 12,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              ex_redirect_i,
    input  logic [31:0]       ex_target_i,
    input  logic              id_redirect_i,
    input  logic [31:0]       id_target_i,
    if_stage_if.master        mem,
    output logic [31:0]       inst_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    output logic [31:0]       fetch_cnt_o
);

    state_e      state_q;
    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] fetch_cnt_q;
    logic        region_ok;

    if_stage_pc_sel #(
        .RESET_PC (RESET_PC)
    ) u_pc_sel (
        .rst           (rst),
        .stall_i       (stall_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .id_redirect_i (id_redirect_i),
        .id_target_i   (id_target_i),
        .boot_i        (state_q == BOOT),
        .pc_q_i        (pc_q),
        .fetch_addr_o  (pc_d)
    );

    // Memories register the address, so their data lines up with pc_q next cycle.
    assign mem.bios_addr = pc_d[BIOS_AW+1:2];
    assign mem.imem_addr = pc_d[IMEM_AW+1:2];

    always_comb begin
        inst_o    = NOP_INST;
        region_ok = 1'b0;
        case (pc_q[31:28])
            REGION_BIOS: begin
                inst_o    = mem.bios_dout;
                region_ok = 1'b1;
            end
            REGION_IMEM: begin
                inst_o    = mem.imem_dout;
                region_ok = 1'b1;
            end
            default: begin
                inst_o    = NOP_INST;
                region_ok = 1'b0;
            end
        endcase
    end

    assign valid_o     = valid_q & region_ok & ~ex_redirect_i & ~id_redirect_i;
    assign pc_o        = pc_q;
    assign fetch_cnt_o = fetch_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (valid_o && !stall_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle expectations queued by the driver, checked by a monitor.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        ex_redirect_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        id_redirect_i = 1'b0;
    logic [31:0] id_target_i = '0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic [31:0] fetch_cnt_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] cnt;
        int          v;
        bit          ci;
        logic [31:0] inst;
        int          ba;
        int          ia;
    } exp_t;

    exp_t exp_q[$];

    if_stage_if #(.BIOS_AW(12), .IMEM_AW(14)) mem_if ();

    if_stage #(
        .RESET_PC (32'h4000_0000),
        .BIOS_AW  (12),
        .IMEM_AW  (14)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .id_redirect_i (id_redirect_i),
        .id_target_i   (id_target_i),
        .mem           (mem_if),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // Word n of BIOS reads as B000_0000+n, IMEM as D000_0000+n.
    always @(posedge clk) begin
        mem_if.bios_dout <= 32'hB000_0000 | 32'(mem_if.bios_addr);
        mem_if.imem_dout <= 32'hD000_0000 | 32'(mem_if.imem_addr);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endfunction

    task automatic step(input logic r, input logic st, input logic exr, input logic [31:0] ext,
                        input logic idr, input logic [31:0] idt);
        @(negedge clk);
        rst           = r;
        stall_i       = st;
        ex_redirect_i = exr;
        ex_target_i   = ext;
        id_redirect_i = idr;
        id_target_i   = idt;
    endtask

    task automatic expect_cyc(input string nm, input logic [31:0] pc, input logic [31:0] cnt,
                              input int v, input bit ci, input logic [31:0] inst,
                              input int ba, input int ia);
        exp_t e;
        e.name = nm; e.pc = pc; e.cnt = cnt; e.v = v;
        e.ci = ci; e.inst = inst; e.ba = ba; e.ia = ia;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".pc"}, pc_o, e.pc);
                chk({e.name, ".cnt"}, fetch_cnt_o, e.cnt);
                if (e.v >= 0) chk({e.name, ".valid"}, {31'b0, valid_o}, 32'(e.v));
                if (e.ci) chk({e.name, ".inst"}, inst_o, e.inst);
                if (e.ba >= 0) chk({e.name, ".bios_addr"}, 32'(mem_if.bios_addr), 32'(e.ba));
                if (e.ia >= 0) chk({e.name, ".imem_addr"}, 32'(mem_if.imem_addr), 32'(e.ia));
            end
        end
    end

    initial begin : driver
        repeat (3) @(negedge clk);

        step(1, 0, 0, '0, 0, '0);
        expect_cyc("rel0", 32'h4000_0000, 0, 0, 0, '0, 0, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("rel1", 32'h4000_0000, 0, 1, 1, 32'hB000_0000, -1, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("rel2", 32'h4000_0004, 1, 1, 1, 32'hB000_0001, -1, -1);

        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, '0, 0, '0);
            expect_cyc($sformatf("stall%0d", i), 32'h4000_0008, 2, 1, 1, 32'hB000_0002, 2, -1);
        end
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("resume", 32'h4000_0008, 2, 1, 1, 32'hB000_0002, -1, -1);

        step(1, 0, 1, 32'h1000_0102, 0, '0);
        expect_cyc("exkill", 32'h4000_000C, 3, 0, 1, 32'hB000_0003, -1, 14'h0040);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("exland", 32'h1000_0100, 3, 1, 1, 32'hD000_0040, -1, -1);

        step(1, 1, 1, 32'h4000_0040, 1, 32'h4000_0080);
        expect_cyc("simkill", 32'h1000_0104, 4, 0, 1, 32'hD000_0041, 12'h010, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("simland", 32'h4000_0040, 4, 1, 1, 32'hB000_0010, -1, -1);

        step(1, 1, 0, '0, 1, 32'h4000_0080);
        expect_cyc("idstall", 32'h4000_0044, 5, 0, 1, 32'hB000_0011, 12'h011, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("idhold", 32'h4000_0044, 5, 1, 1, 32'hB000_0011, -1, -1);
        step(1, 0, 0, '0, 1, 32'h4000_0083);
        expect_cyc("idkill", 32'h4000_0048, 6, 0, 1, 32'hB000_0012, 12'h020, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("idland", 32'h4000_0080, 6, 1, 1, 32'hB000_0020, -1, -1);

        step(1, 0, 1, 32'h2000_0000, 0, '0);
        expect_cyc("badkill", 32'h4000_0084, 7, 0, 1, 32'hB000_0021, -1, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("bad0", 32'h2000_0000, 7, 0, 1, 32'h0000_0013, -1, -1);
        step(1, 0, 1, 32'h4000_0000, 0, '0);
        expect_cyc("bad1", 32'h2000_0004, 7, 0, 1, 32'h0000_0013, 0, -1);

        step(1, 0, 0, '0, 0, '0);
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        expect_cyc("wrap0", 32'h4000_0000, 32'hFFFF_FFFF, 1, 1, 32'hB000_0000, -1, -1);

        step(0, 1, 0, '0, 0, '0);
        expect_cyc("wrap1", 32'h4000_0004, 0, -1, 1, 32'hB000_0001, 0, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("rstmid", 32'h4000_0000, 0, 0, 0, '0, -1, -1);
        step(1, 0, 0, '0, 0, '0);
        expect_cyc("rstrun", 32'h4000_0000, 0, 1, 1, 32'hB000_0000, -1, -1);

        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC register and drives the synchronous-read BIOS and IMEM address ports.
- Selects the returned instruction word by memory region and presents inst/pc/valid to the IF/ID boundary.
- Handles hazard-unit stalls, redirects from EX (jalr/mispredict) and ID (jal/taken branch), and keeps a retired-fetch counter for the CSR block.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset (BIOS base).
- BIOS_AW, 12, BIOS word-address width.
- IMEM_AW, 14, IMEM word-address width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (state resets on a clk edge while rst==0).
- stall_i  in  1  hazard unit: hold the current fetch.
- ex_redirect_i  in  1  EX redirect request.
- ex_target_i  in  32  EX redirect target.
- id_redirect_i  in  1  ID redirect request.
- id_target_i  in  32  ID redirect target (decode branch_addr).
- bios_addr_o  out  BIOS_AW  equals fetch_addr[BIOS_AW+1:2].
- imem_addr_o  out  IMEM_AW  equals fetch_addr[IMEM_AW+1:2].
- bios_dout_i  in  32  BIOS data, one cycle after address.
- imem_dout_i  in  32  IMEM data, one cycle after address.
- inst_o  out  32  instruction at pc_o.
- pc_o  out  32  PC of inst_o (pc_q).
- valid_o  out  1  inst_o is a real, non-killed instruction.
- fetch_cnt_o  out  32  count of instructions accepted downstream.

Behaviour:
- fetch_addr is combinational. Priority, highest first:
  - rst==0 → RESET_PC
  - ex_redirect_i → {ex_target_i[31:2],2'b00}
  - stall_i → pc_q
  - id_redirect_i → {id_target_i[31:2],2'b00}
  - state==BOOT → pc_q
  - else → pc_q+4, with 32-bit wrap and no carry out.
- On each edge with rst==1: pc_q <= fetch_addr. Memory data is therefore aligned with pc_q with one cycle of latency.
- Region select on pc_q[31:28]:
  - 4'h4 → bios_dout_i
  - 4'h1 → imem_dout_i
  - any other value → inst_o = 32'h0000_0013 (NOP) and region_ok = 0.
- valid_o = valid_q & region_ok & ~ex_redirect_i & ~id_redirect_i. The wrong-path word is killed in the same cycle as the redirect.
- Simultaneous events:
  - EX redirect overrides stall and ID redirect.
  - ID redirect during stall is ignored; decode re-presents it after the stall.
  - valid_o is still computed during a stall; downstream must not latch while stalled.
- FSM, 2 states:
  - BOOT: entered on reset. valid_q = 0. PC holds so RESET_PC is re-read. Next state RUN unconditionally.
  - RUN: valid_q = 1.
  - There is no state change on stall or redirect. Redirect bubbles come from the valid_o kill term only.
- fetch_cnt_o increments by 1 on an edge where valid_o==1 && stall_i==0. It wraps from 32'hFFFF_FFFF to 0.
- Reset values (edge with rst==0): pc_q = RESET_PC, state = BOOT, fetch_cnt = 0.
- Outputs in the first cycle after reset release: valid_o = 0, pc_o = RESET_PC, fetch_cnt_o = 0.
- Reset asserted mid-operation overrides stall and redirects on that edge. There is no partial state.
- Redirect target bits [1:0] are discarded. There is no misalignment trap at this stage.

Decomposition:
- Shared defines header:
  - RESET_PC default
  - region codes REGION_BIOS = 4'h4, REGION_IMEM = 4'h1
  - NOP encoding 32'h0000_0013
  - FSM state encodings (BOOT, RUN)
- One natural sub-module: pc_sel, the combinational next-PC priority mux. It is also reused by the fetch unit-level bench.
- Counter and region mux stay inline.

Test Plan:
- Reset release:
  - Stimulus: hold rst=0 for 3 cycles, release, memories return sequential words.
  - Required: cycle0 valid_o=0, pc_o=32'h4000_0000; cycle1 valid_o=1, pc_o=32'h4000_0000; cycle2 pc_o=32'h4000_0004; fetch_cnt_o=2 after cycle2.
- Stall:
  - Stimulus: stall_i=1 for 3 cycles at pc_o=32'h4000_0008.
  - Required: pc_o and inst_o constant, bios_addr_o=12'h002, fetch_cnt_o frozen; resume at 32'h4000_000C.
- EX redirect into IMEM:
  - Stimulus: ex_redirect_i=1, ex_target_i=32'h1000_0102.
  - Required: same cycle valid_o=0; next cycle pc_o=32'h1000_0100, imem_addr_o had 14'h0040, inst_o=imem_dout_i.
- Simultaneous events:
  - Stimulus: ex_redirect_i, id_redirect_i and stall_i all 1, ex_target=32'h4000_0040, id_target=32'h4000_0080.
  - Required: next pc_o=32'h4000_0040.
  - Stimulus: id_redirect_i with stall_i.
  - Required: PC held.
- Bad region:
  - Stimulus: ex_target_i=32'h2000_0000.
  - Required: inst_o=32'h0000_0013, valid_o=0, fetch_cnt_o unchanged.
- Counter wrap and reset:
  - Stimulus: force fetch_cnt=32'hFFFF_FFFF, deliver one valid instruction.
  - Required: fetch_cnt_o=0.
  - Stimulus: assert rst mid-stall.
  - Required: next cycle pc_o=RESET_PC, valid_o=0.
